fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the pipelined processor. It drives the program counter and a one-cycle-latency synchronous instruction memory. It buffers the returning instruction into IF/ID and decodes the 4-bit fields that hazard detection and decode consume. It honours the hazard stall (IF_ID_Hold) without losing an in-flight fetch, and flushes on a branch redirect.

## Interface
- PC_WIDTH, 8, program counter / instruction address width
- RESET_PC, 0, PC value loaded on reset
- NOP_INSTR, 16'hF000, instruction presented while IF/ID holds no valid instruction (opcode 4'b1111)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- hold  in  1  IF_ID_Hold from hazard detection; 1 freezes IF/ID and stops issuing
- redirect  in  1  branch taken; flush fetch path and reload PC
- redirect_pc  in  PC_WIDTH  new PC when redirect=1
- imem_rd  out  1  read strobe, combinational
- imem_addr  out  PC_WIDTH  read address (= PC)
- imem_data  in  16  instruction, valid the cycle after imem_rd=1
- IF_ID_valid  out  1  IF/ID holds a real instruction
- IF_ID_instr  out  16  registered instruction
- IF_ID_pc  out  PC_WIDTH  address of IF_ID_instr
- IF_ID_opcode, IF_ID_dest, IF_ID_op1, IF_ID_op2  out  4 each  instr[15:12], [11:8], [7:4], [3:0]

## Operation
- State: pc, pending flag with pending_pc, one-entry skid buffer (skid_valid, skid_instr, skid_pc), IF/ID register.
- Issue: imem_rd = reset & ~hold & ~redirect. On issue: imem_addr=pc, pending<=1, pending_pc<=pc, pc<=pc+1, wrapping from 2^PC_WIDTH-1 to 0.
- Return: when pending=1, imem_data is valid this cycle. With hold=0 and skid empty, it loads IF/ID. With hold=1, it loads the skid. pending clears unless a new issue occurs.
- IF/ID load when hold=0, highest priority first: skid (then skid_valid<=0), else returning data, else bubble (valid=0, instr=NOP_INSTR, pc unchanged).
- The skid cannot overflow: no issue occurs while hold=1, so at most one return lands during a stall.
- hold=1 with no redirect: IF/ID, pc and skid unchanged.
- redirect=1 overrides hold: IF_ID_valid<=0, IF_ID_instr<=NOP_INSTR, skid_valid<=0, pending<=0 (returning data discarded), pc<=redirect_pc, no issue. Fetch of redirect_pc issues next cycle if hold=0.
- Field outputs are combinational slices of IF_ID_instr. An invalid slot therefore shows opcode 4'b1111, which is not a hazard opcode.

## Timing
- Reset (asynchronous): pc=RESET_PC, pending=0, skid_valid=0, IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_pc=0.
- imem_rd=0 while reset=0. The first issue occurs in the first cycle with reset=1 and hold=0.
- Latency: issue in cycle N, data in N+1, visible on IF_ID_* in N+2. Throughput is one instruction per cycle while hold=0.
- Stall release: in the first cycle with hold=0, IF/ID takes the skid and a new fetch issues. The next instruction follows in the next cycle with no gap and no duplicate.
- Redirect in cycle R: IF_ID_valid=0 in R+1. First redirected instruction valid in R+3 (issue R+1).
- Reset asserted mid-stall or mid-fetch discards pending and skid contents. No instruction from before reset appears afterwards.

## Test plan
- Reset then free run, imem_data = addr-tagged words (0x1000+addr): IF_ID_pc 0,1,2… from cycle 2 after reset release, IF_ID_valid=1 every cycle, imem_rd=1 each cycle.
- hold=1 for 3 cycles while pc 5 returning: IF_ID frozen on pc 4, imem_rd=0. After release, IF_ID shows pc 5, then 6, with no skip or duplicate.
- redirect=1 with redirect_pc=0x40 while pc 9 pending: IF_ID_valid=0 and IF_ID_opcode=4'hF next cycle, pc 9 never appears, pc 0x40 valid 3 cycles after redirect.
- redirect and hold both 1 in the same cycle: flush takes effect, skid cleared. Once hold drops, fetch resumes from redirect_pc.
- PC wrap: RESET_PC=8'hFE gives IF_ID_pc sequence FE, FF, 00, 01.
- Async reset asserted while skid full: outputs go to reset values without a clock edge. After release, first valid IF_ID_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues one read per cycle to a 1-cycle synchronous imem; a one-entry skid catches the return that lands during a stall.
module fetch_stage #(
  parameter int                  PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
  parameter logic [15:0]         NOP_INSTR = 16'hF000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_rd,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic                IF_ID_valid,
  output logic [15:0]         IF_ID_instr,
  output logic [PC_WIDTH-1:0] IF_ID_pc,
  output logic [3:0]          IF_ID_opcode,
  output logic [3:0]          IF_ID_dest,
  output logic [3:0]          IF_ID_op1,
  output logic [3:0]          IF_ID_op2
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pending_q, pending_d;
  logic [PC_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic [15:0]         skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                if_valid_q, if_valid_d;
  logic [15:0]         if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                issue_s;

  assign issue_s   = reset & ~hold & ~redirect;
  assign imem_rd   = issue_s;
  assign imem_addr = pc_q;

  // Next-state for PC, in-flight tracking, skid buffer and IF/ID register
  always_comb begin
    pc_d         = pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;

    if (redirect) begin
      // Flush overrides hold; any returning data is dropped
      pc_d         = redirect_pc;
      pending_d    = 1'b0;
      skid_valid_d = 1'b0;
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
    end else begin
      if (issue_s) begin
        pc_d         = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        pending_d    = 1'b1;
        pending_pc_d = pc_q;
      end else begin
        pending_d    = 1'b0;
      end

      if (hold) begin
        if (pending_q) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_data;
          skid_pc_d    = pending_pc_q;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end else if (skid_valid_q) begin
        if_valid_d = 1'b1;
        if_instr_d = skid_instr_q;
        if_pc_d    = skid_pc_q;
        // Keep a simultaneous return rather than lose it (not expected in normal flow)
        if (pending_q) begin
          skid_instr_d = imem_data;
          skid_pc_d    = pending_pc_q;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (pending_q) begin
        if_valid_d = 1'b1;
        if_instr_d = imem_data;
        if_pc_d    = pending_pc_q;
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
    end
  end

  // State registers, cleared asynchronously by active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= {PC_WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= {PC_WIDTH{1'b0}};
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= {PC_WIDTH{1'b0}};
    end else begin
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  assign IF_ID_valid  = if_valid_q;
  assign IF_ID_instr  = if_instr_q;
  assign IF_ID_pc     = if_pc_q;
  assign IF_ID_opcode = if_instr_q[15:12];
  assign IF_ID_dest   = if_instr_q[11:8];
  assign IF_ID_op1    = if_instr_q[7:4];
  assign IF_ID_op2    = if_instr_q[3:0];

endmodule
